// File: rtl/ttl_bus_arbiter.sv
// ttl_bus_arbiter
//   Round-robin arbiter sharing one tristate data bus among NREQ octal output
//   registers. Converts level bus requests into a one-hot grant and matching
//   active-low output enables, with DEAD idle cycles between consecutive
//   owners so no two registers ever drive the bus together.
//
//   Optional feature macro: BUS_ARB_TIMEOUT_EN
//     When defined, an owner is forced off the bus after TENURE grant cycles
//     if another requester is waiting. When undefined, an owner keeps the bus
//     until it drops its request.
//
// Ports
//   clk        : sole clock, all state updates on rising edge
//   reset      : synchronous active-high reset
//   Req        : per-requester bus request (level, active-high)
//   Grant      : registered one-hot grant
//   Output_bar : registered active-low output enables, always ~Grant
//   Owner      : index of the current owner, valid while Busy
//   Busy       : registered, high while any Grant bit is high
module ttl_bus_arbiter #(
  parameter  int unsigned NREQ    = 4,
  parameter  int unsigned DEAD    = 1,
  parameter  int unsigned TENURE  = 8,
  localparam int unsigned OWNER_W = $clog2(NREQ)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NREQ-1:0]    Req,
  output logic [NREQ-1:0]    Grant,
  output logic [NREQ-1:0]    Output_bar,
  output logic [OWNER_W-1:0] Owner,
  output logic               Busy
);

  localparam int unsigned DEAD_W = 2;
  localparam int unsigned TEN_W  = 8;

  // Elaboration-time parameter range check
  if (NREQ < 2 || NREQ > 8 || DEAD < 1 || DEAD > 3 || TENURE < 2 || TENURE > 255) begin : g_param_check
    $error("ttl_bus_arbiter: parameter out of range");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    TURN  = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [NREQ-1:0]      grant_q, grant_d;
  logic [NREQ-1:0]      oe_bar_q, oe_bar_d;
  logic                 busy_q, busy_d;
  logic [OWNER_W-1:0]   owner_q, owner_d;
  logic [OWNER_W-1:0]   last_q, last_d;
  logic [DEAD_W-1:0]    dead_q, dead_d;

  logic                 win_found;
  logic [OWNER_W-1:0]   win_idx;
  logic [OWNER_W-1:0]   cand_idx;
  logic                 release_owner;

`ifdef BUS_ARB_TIMEOUT_EN
  logic [TEN_W-1:0]     tenure_q, tenure_d;
  logic                 other_req;
`endif

  // Round-robin search: Last+1, Last+2, ..., Last (mod NREQ); first request wins
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand_idx  = '0;
    for (int unsigned i = 1; i <= NREQ; i++) begin
      cand_idx = OWNER_W'((32'(last_q) + i) % NREQ);
      if (!win_found && Req[cand_idx]) begin
        win_found = 1'b1;
        win_idx   = cand_idx;
      end
    end
  end

`ifdef BUS_ARB_TIMEOUT_EN
  // Any requester other than the current owner is waiting
  always_comb begin
    other_req = |(Req & ~grant_q);
  end
`endif

  // Next-state and next-output logic
  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    owner_d       = owner_q;
    last_d        = last_q;
    dead_d        = dead_q;
    release_owner = 1'b0;
`ifdef BUS_ARB_TIMEOUT_EN
    tenure_d      = tenure_q;
`endif

    unique case (state_q)
      IDLE: begin
        grant_d = '0;
        if (win_found) begin
          state_d = GRANT;
          grant_d = NREQ'(1) << win_idx;
          owner_d = win_idx;
          last_d  = win_idx;
`ifdef BUS_ARB_TIMEOUT_EN
          tenure_d = TEN_W'(1);
`endif
        end
      end

      GRANT: begin
        release_owner = !Req[owner_q];
`ifdef BUS_ARB_TIMEOUT_EN
        if (tenure_q == TEN_W'(TENURE) && other_req) begin
          release_owner = 1'b1;
        end
`endif
        if (release_owner) begin
          state_d = TURN;
          grant_d = '0;
          dead_d  = DEAD_W'(DEAD - 1);
`ifdef BUS_ARB_TIMEOUT_EN
          tenure_d = '0;
`endif
        end else begin
`ifdef BUS_ARB_TIMEOUT_EN
          // Saturate so a lone owner keeps the bus indefinitely
          if (tenure_q != TEN_W'(TENURE)) begin
            tenure_d = tenure_q + TEN_W'(1);
          end
`endif
        end
      end

      TURN: begin
        grant_d = '0;
        // Requests are only looked at on the edge that ends the last dead cycle
        if (dead_q == '0) begin
          if (win_found) begin
            state_d = GRANT;
            grant_d = NREQ'(1) << win_idx;
            owner_d = win_idx;
            last_d  = win_idx;
`ifdef BUS_ARB_TIMEOUT_EN
            tenure_d = TEN_W'(1);
`endif
          end else begin
            state_d = IDLE;
          end
        end else begin
          dead_d = dead_q - DEAD_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase

    oe_bar_d = ~grant_d;
    busy_d   = |grant_d;
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      oe_bar_q <= '1;
      busy_q   <= 1'b0;
      owner_q  <= '0;
      last_q   <= OWNER_W'(NREQ - 1);
      dead_q   <= '0;
`ifdef BUS_ARB_TIMEOUT_EN
      tenure_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      oe_bar_q <= oe_bar_d;
      busy_q   <= busy_d;
      owner_q  <= owner_d;
      last_q   <= last_d;
      dead_q   <= dead_d;
`ifdef BUS_ARB_TIMEOUT_EN
      tenure_q <= tenure_d;
`endif
    end
  end

  assign Grant      = grant_q;
  assign Output_bar = oe_bar_q;
  assign Busy       = busy_q;
  assign Owner      = owner_q;

endmodule

// File: tb/tb_ttl_bus_arbiter.sv
// Testbench for ttl_bus_arbiter (NREQ=4, DEAD=1, TENURE=8).
// Directed steps push the expected grant for the coming edge into a queue;
// the entry is popped and compared on the following falling edge.
module tb_ttl_bus_arbiter;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] Req = 4'b1111;
  logic [3:0] Grant;
  logic [3:0] Output_bar;
  logic [1:0] Owner;
  logic       Busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      tag;
    logic [3:0] grant;
    logic       rst;
  } exp_t;

  exp_t sb[$];

  ttl_bus_arbiter #(.NREQ(4), .DEAD(1), .TENURE(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .Req        (Req),
    .Grant      (Grant),
    .Output_bar (Output_bar),
    .Owner      (Owner),
    .Busy       (Busy)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] oh(input int k);
    logic [3:0] one;
    one = 4'b0001;
    return one << k;
  endfunction

  function automatic logic [1:0] idx_of(input logic [3:0] g);
    logic [1:0] r;
    r = 2'd0;
    for (int i = 0; i < 4; i++) if (g[i]) r = 2'(i);
    return r;
  endfunction

  // Bus-safety monitor: enables mirror Grant, never two drivers, no direct handover
  logic [3:0] prev_grant = 4'b0000;
  always @(negedge clk) begin
    checks++;
    assert (Output_bar === ~Grant) else begin
      errors++;
      $error("FAIL mon_oe_eq observed=%b expected=%b", Output_bar, ~Grant);
    end
    checks++;
    assert ($countones(~Output_bar) <= 1) else begin
      errors++;
      $error("FAIL mon_two_low observed=%b expected=at most one low bit", Output_bar);
    end
    if (prev_grant != 4'b0000 && Grant != 4'b0000) begin
      checks++;
      assert (Grant === prev_grant) else begin
        errors++;
        $error("FAIL mon_handover observed=%b expected=%b", Grant, prev_grant);
      end
    end
    prev_grant = Grant;
  end

  task automatic check_out();
    exp_t e;
    e = sb.pop_front();
    checks++;
    assert (Grant === e.grant) else begin
      errors++;
      $error("FAIL %s grant observed=%b expected=%b", e.tag, Grant, e.grant);
    end
    checks++;
    assert (Output_bar === ~e.grant) else begin
      errors++;
      $error("FAIL %s output_bar observed=%b expected=%b", e.tag, Output_bar, ~e.grant);
    end
    checks++;
    assert (Busy === (|e.grant)) else begin
      errors++;
      $error("FAIL %s busy observed=%b expected=%b", e.tag, Busy, |e.grant);
    end
    if (e.grant != 4'b0000) begin
      checks++;
      assert (Owner === idx_of(e.grant)) else begin
        errors++;
        $error("FAIL %s owner observed=%0d expected=%0d", e.tag, Owner, idx_of(e.grant));
      end
    end
    if (e.rst) begin
      checks++;
      assert (Owner === 2'd0) else begin
        errors++;
        $error("FAIL %s owner_rst observed=%0d expected=0", e.tag, Owner);
      end
    end
  endtask

  // Drive one cycle of inputs, record what Grant must be after the next edge
  task automatic cyc(input logic r, input logic [3:0] req, input logic [3:0] exp, input string tag);
    exp_t e;
    reset   = r;
    Req     = req;
    e.tag   = tag;
    e.grant = exp;
    e.rst   = r;
    sb.push_back(e);
    @(negedge clk);
    check_out();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held two cycles with all requests up
    cyc(1'b1, 4'b1111, 4'b0000, "rst0");
    cyc(1'b1, 4'b1111, 4'b0000, "rst1");
    cyc(1'b0, 4'b1111, 4'b0001, "first");

    // Round-robin: each owner holds 3 cycles, drops for one
    for (int k = 0; k < 4; k++) begin
      cyc(1'b0, 4'b1111, oh(k), "rr_hold");
      cyc(1'b0, 4'b1111, oh(k), "rr_hold");
      cyc(1'b0, 4'b1111 & ~oh(k), 4'b0000, "rr_dead");
      cyc(1'b0, 4'b1111, oh((k + 1) % 4), "rr_next");
    end

    // Break-before-make between requesters 0 and 1
    cyc(1'b0, 4'b0011, 4'b0001, "bbm_hold");
    cyc(1'b0, 4'b0010, 4'b0000, "bbm_dead");
    cyc(1'b0, 4'b0010, 4'b0010, "bbm_next");
    cyc(1'b0, 4'b0000, 4'b0000, "bbm_rel");
    cyc(1'b0, 4'b0000, 4'b0000, "idle1");

    // Last=1, requests 0 and 3 together: 3 is next in order
    cyc(1'b0, 4'b1001, 4'b1000, "simul");
    cyc(1'b0, 4'b0000, 4'b0000, "simul_rel");
    cyc(1'b0, 4'b0000, 4'b0000, "idle2");

    // Sole requester re-asserting still sees a dead cycle
    cyc(1'b0, 4'b0100, 4'b0100, "sole_gnt");
    cyc(1'b0, 4'b0000, 4'b0000, "sole_dead");
    cyc(1'b0, 4'b0100, 4'b0100, "sole_regnt");

`ifdef BUS_ARB_TIMEOUT_EN
    // Owner 2 forced off after 8 cycles while requester 0 waits
    for (int k = 0; k < 7; k++) cyc(1'b0, 4'b0101, 4'b0100, "to_hold");
    cyc(1'b0, 4'b0101, 4'b0000, "to_dead");
    cyc(1'b0, 4'b0101, 4'b0001, "to_next");
    cyc(1'b0, 4'b0100, 4'b0000, "to_dead2");
    cyc(1'b0, 4'b0100, 4'b0100, "to_back");
    // Alone on the bus, owner keeps it past the tenure limit
    for (int k = 0; k < 20; k++) cyc(1'b0, 4'b0100, 4'b0100, "to_alone");
`else
    // No timeout: owner 2 keeps the bus despite requester 0 waiting
    for (int k = 0; k < 22; k++) cyc(1'b0, 4'b0101, 4'b0100, "no_to_hold");
`endif

    // Reset while requester 2 owns the bus; pointer returns to 3
    cyc(1'b1, 4'b1111, 4'b0000, "rst_mid");
    cyc(1'b0, 4'b1111, 4'b0001, "post_rst");

    checks++;
    assert (sb.size() == 0) else begin
      errors++;
      $error("FAIL sb_empty observed=%0d expected=0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
